// File: rtl/score_display_driver_pkg.sv
// score_display_pkg: shared FSM states, active-low segment codes and score width
package score_display_pkg;
  localparam int SCORE_W = 7;
  typedef enum logic [1:0] {IDLE, CONV, LATCH} state_e;
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
endpackage

// File: rtl/score_display_driver_if.sv
// score_display_driver_if: score in (master drives) and hex0_n/hex1_n/hex2_n, busy, update_p out (slave drives)
interface score_display_driver_if;
  import score_display_pkg::*;
  logic [SCORE_W-1:0] score;
  logic [6:0]         hex0_n;
  logic [6:0]         hex1_n;
  logic [6:0]         hex2_n;
  logic               busy;
  logic               update_p;
  modport master (output score, input hex0_n, hex1_n, hex2_n, busy, update_p);
  modport slave  (input score, output hex0_n, hex1_n, hex2_n, busy, update_p);
endinterface

// File: rtl/score_display_driver_seg7_decode.sv
// seg7_decode: digit[3:0] + blank in, seg_n[6:0] active-low out (bit0=a..bit6=g); digits above 9 decode blank
module seg7_decode
  import score_display_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg_n
);
  always_comb begin
    seg_n = SEG_BLANK;
    if (!blank) begin
      case (digit)
        4'd0:    seg_n = SEG_0;
        4'd1:    seg_n = SEG_1;
        4'd2:    seg_n = SEG_2;
        4'd3:    seg_n = SEG_3;
        4'd4:    seg_n = SEG_4;
        4'd5:    seg_n = SEG_5;
        4'd6:    seg_n = SEG_6;
        4'd7:    seg_n = SEG_7;
        4'd8:    seg_n = SEG_8;
        4'd9:    seg_n = SEG_9;
        default: seg_n = SEG_BLANK;
      endcase
    end
  end
endmodule

// File: rtl/score_display_driver.sv
// score_display_driver: clk, reset_n (async low), bus.score in -> sequential double-dabble -> bus.hex0_n/hex1_n/hex2_n, busy, update_p
module score_display_driver
  import score_display_pkg::*;
#(
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  score_display_driver_if.slave bus
);
  localparam logic [6:0] LEAD_RST = BLANK_LEADING ? SEG_BLANK : SEG_0;
  state_e             state_q, state_d;
  logic [SCORE_W-1:0] shadow_q, shadow_d, shift_q, shift_d;
  logic [9:0]         bcd_q, bcd_d;
  logic [2:0]         cnt_q, cnt_d;
  logic [6:0]         hex0_q, hex0_d, hex1_q, hex1_d, hex2_q, hex2_d;
  logic               update_q, update_d;
  logic [3:0]         ones_a, tens_a;
  logic [6:0]         seg0, seg1, seg2;
  // hundreds can only reach 1, so only tens and ones get the add-3 correction
  assign ones_a = bcd_q[3:0] >= 4'd5 ? bcd_q[3:0] + 4'd3 : bcd_q[3:0];
  assign tens_a = bcd_q[7:4] >= 4'd5 ? bcd_q[7:4] + 4'd3 : bcd_q[7:4];
  seg7_decode u_dig0 (.digit(bcd_q[3:0]), .blank(1'b0), .seg_n(seg0));
  seg7_decode u_dig1 (.digit(bcd_q[7:4]),
                      .blank(BLANK_LEADING && bcd_q[9:8] == 2'd0 && bcd_q[7:4] == 4'd0),
                      .seg_n(seg1));
  seg7_decode u_dig2 (.digit({2'b00, bcd_q[9:8]}),
                      .blank(BLANK_LEADING && bcd_q[9:8] == 2'd0),
                      .seg_n(seg2));
  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    shift_d  = shift_q;
    bcd_d    = bcd_q;
    cnt_d    = cnt_q;
    hex0_d   = hex0_q;
    hex1_d   = hex1_q;
    hex2_d   = hex2_q;
    update_d = 1'b0;
    case (state_q)
      IDLE: if (bus.score != shadow_q) begin
        shadow_d = bus.score;
        shift_d  = bus.score;
        bcd_d    = '0;
        cnt_d    = '0;
        state_d  = CONV;
      end
      CONV: begin
        bcd_d   = {bcd_q[8], tens_a, ones_a, shift_q[SCORE_W-1]};
        shift_d = {shift_q[SCORE_W-2:0], 1'b0};
        cnt_d   = cnt_q + 3'd1;
        state_d = cnt_q == 3'd6 ? LATCH : CONV;
      end
      LATCH: begin
        hex0_d   = seg0;
        hex1_d   = seg1;
        hex2_d   = seg2;
        update_d = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      shift_q  <= '0;
      bcd_q    <= '0;
      cnt_q    <= '0;
      hex0_q   <= SEG_0;
      hex1_q   <= LEAD_RST;
      hex2_q   <= LEAD_RST;
      update_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      shift_q  <= shift_d;
      bcd_q    <= bcd_d;
      cnt_q    <= cnt_d;
      hex0_q   <= hex0_d;
      hex1_q   <= hex1_d;
      hex2_q   <= hex2_d;
      update_q <= update_d;
    end
  end
  assign bus.hex0_n   = hex0_q;
  assign bus.hex1_n   = hex1_q;
  assign bus.hex2_n   = hex2_q;
  assign bus.busy     = state_q != IDLE;
  assign bus.update_p = update_q;
endmodule
